// File: rtl/sigen_pkg.sv
// Shared types and constants for the sine-generator sweep sequencing blocks.
package sigen_pkg;

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} sweep_state_t;

  localparam int unsigned DWELL_MIN = 1;

endpackage

// File: rtl/sine_sweep_ctrl_if.sv
// Control/status bundle between a sweep control source and sine_sweep_ctrl.
interface sine_sweep_ctrl_if #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic                   continuous;
  logic [D_WIDTH-1:0]     incr_lo;
  logic [D_WIDTH-1:0]     incr_hi;
  logic [D_WIDTH-1:0]     step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic                   gen_en;
  logic [D_WIDTH-1:0]     gen_incr;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;

  modport master (
    output start, abort, continuous, incr_lo, incr_hi, step, dwell,
    input  gen_en, gen_incr, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, continuous, incr_lo, incr_hi, step, dwell,
    output gen_en, gen_incr, busy, done, cfg_err
  );
endinterface

// File: rtl/dwell_timer.sv
// Down-counter that flags the last cycle a value is held; load restarts it at max(value, 1).
module dwell_timer
  import sigen_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value < WIDTH'(DWELL_MIN)) ? WIDTH'(DWELL_MIN) : value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == WIDTH'(DWELL_MIN));

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Triangle frequency-sweep sequencer driving the sine generator's en/incr inputs.
module sine_sweep_ctrl
  import sigen_pkg::*;
#(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  sine_sweep_ctrl_if.slave  io
);

  sweep_state_t           state_q, state_d;
  logic [D_WIDTH-1:0]     incr_q, incr_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [D_WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d, step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   cont_q, cont_d;

  logic                   tmr_load, tmr_expire;
  logic [DWELL_WIDTH-1:0] tmr_value;

  // One extra bit keeps the saturating add/subtract free of wrap-around.
  logic [D_WIDTH:0]   up_sum, dn_diff, lo_sum;
  logic [D_WIDTH-1:0] up_next, dn_next, wrap_next;

  assign up_sum    = {1'b0, incr_q} + {1'b0, step_q};
  assign dn_diff   = {1'b0, incr_q} - {1'b0, step_q};
  assign lo_sum    = {1'b0, lo_q} + {1'b0, step_q};
  assign up_next   = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[D_WIDTH-1:0];
  assign dn_next   = (dn_diff[D_WIDTH] || (dn_diff[D_WIDTH-1:0] < lo_q)) ? lo_q
                                                                          : dn_diff[D_WIDTH-1:0];
  assign wrap_next = (lo_sum > {1'b0, hi_q}) ? hi_q : lo_sum[D_WIDTH-1:0];

  dwell_timer #(
    .WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    incr_d    = incr_q;
    err_d     = 1'b0;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cont_d    = cont_q;
    tmr_load  = 1'b0;
    tmr_value = dwell_q;

    if (io.abort) begin
      state_d = IDLE;
      incr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          incr_d = '0;
          if (io.start) begin
            if ((io.step != '0) && (io.incr_lo <= io.incr_hi)) begin
              state_d   = UP;
              incr_d    = io.incr_lo;
              lo_d      = io.incr_lo;
              hi_d      = io.incr_hi;
              step_d    = io.step;
              dwell_d   = io.dwell;
              cont_d    = io.continuous;
              tmr_load  = 1'b1;
              tmr_value = io.dwell;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        UP: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            if (incr_q < hi_q) begin
              incr_d = up_next;
            end else begin
              state_d = DOWN;
              incr_d  = dn_next;
            end
          end
        end
        DOWN: begin
          if (tmr_expire) begin
            if (incr_q > lo_q) begin
              incr_d   = dn_next;
              tmr_load = 1'b1;
            end else if (cont_q) begin
              state_d  = UP;
              incr_d   = wrap_next;
              tmr_load = 1'b1;
            end else begin
              state_d = DONE;
              incr_d  = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          incr_d  = '0;
        end
        default: begin
          state_d = IDLE;
          incr_d  = '0;
        end
      endcase
    end

    en_d   = (state_d == UP) || (state_d == DOWN);
    busy_d = en_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      incr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      incr_q  <= incr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
    end
  end

  assign io.gen_en   = en_q;
  assign io.gen_incr = incr_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.cfg_err  = err_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Scoreboard bench for sine_sweep_ctrl: a sweep model queues expected outputs, a monitor pops them.
module tb_sine_sweep_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;

  typedef struct packed {
    logic          en;
    logic [DW-1:0] incr;
    logic          busy;
    logic          done;
    logic          err;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sine_sweep_ctrl_if #(.D_WIDTH(DW), .DWELL_WIDTH(TW)) sw ();

  sine_sweep_ctrl #(
    .D_WIDTH     (DW),
    .DWELL_WIDTH (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (sw)
  );

  rec_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  rec_t mon_act, mon_exp;

  function automatic rec_t mk(bit en, int v, bit b, bit d, bit e);
    rec_t r;
    r.en   = en;
    r.incr = DW'(v);
    r.busy = b;
    r.done = d;
    r.err  = e;
    return r;
  endfunction

  // Monitor: every cycle the DUT presents activity must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && (sw.gen_en || sw.busy || sw.done || sw.cfg_err)) begin
      mon_act = {sw.gen_en, sw.gen_incr, sw.busy, sw.done, sw.cfg_err};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got en=%0b incr=%0d busy=%0b done=%0b err=%0b, want none",
                 mon_act.en, mon_act.incr, mon_act.busy, mon_act.done, mon_act.err);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard: got en=%0b incr=%0d busy=%0b done=%0b err=%0b, want en=%0b incr=%0d busy=%0b done=%0b err=%0b",
                   mon_act.en, mon_act.incr, mon_act.busy, mon_act.done, mon_act.err,
                   mon_exp.en, mon_exp.incr, mon_exp.busy, mon_exp.done, mon_exp.err);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_gen_en"}, int'(sw.gen_en), 0);
    check({name, "_gen_incr"}, int'(sw.gen_incr), 0);
    check({name, "_busy"}, int'(sw.busy), 0);
  endtask

  function automatic int dmax(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  // Rising leg: from 'from' upward by step, clipped at hi.
  task automatic build_up(input int from, input int hi, input int st, output int q[$]);
    int v;
    q = {};
    v = from;
    q.push_back(v);
    while (v < hi) begin
      v = (v + st > hi) ? hi : v + st;
      q.push_back(v);
    end
  endtask

  // Falling leg: starts one step below hi (clipped at lo), ends at lo.
  task automatic build_down(input int hi, input int lo, input int st, output int q[$]);
    int v;
    q = {};
    v = hi;
    do begin
      v = (v - st < lo) ? lo : v - st;
      q.push_back(v);
    end while (v > lo);
  endtask

  task automatic drive_cfg(input int lo, input int hi, input int st, input int dw, input bit cont);
    sw.incr_lo    = DW'(lo);
    sw.incr_hi    = DW'(hi);
    sw.step       = DW'(st);
    sw.dwell      = TW'(dw);
    sw.continuous = cont;
  endtask

  task automatic scramble();
    sw.incr_lo    = DW'($urandom);
    sw.incr_hi    = DW'($urandom);
    sw.step       = DW'($urandom_range(0, 3));
    sw.dwell      = TW'($urandom_range(0, 5));
    sw.continuous = 1'($urandom);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_sweep(input string name, input int lo, input int hi, input int st,
                          input int dw, input bit busy_start);
    int u[$], dn[$], seq[$];
    build_up(lo, hi, st, u);
    build_down(hi, lo, st, dn);
    seq = {u, dn};
    @(posedge clk); #1;
    drive_cfg(lo, hi, st, dw, 1'b0);
    sw.start = 1'b1;
    foreach (seq[i]) repeat (dmax(dw)) exp_q.push_back(mk(1, seq[i], 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    @(posedge clk); #1;
    if (busy_start) begin
      scramble();
      sw.start = 1'b1;
      @(posedge clk); #1;
    end
    sw.start = 1'b0;
    scramble();
    wait_drain(name, 4000);
  endtask

  // Continuous sweep aborted after n active cycles.
  task automatic do_cont(input string name, input int lo, input int hi, input int st,
                         input int dw, input int n);
    int u[$], dn[$], seq[$];
    int wrap;
    rec_t r[$];
    build_up(lo, hi, st, u);
    build_down(hi, lo, st, dn);
    seq  = {u, dn};
    wrap = (lo + st > hi) ? hi : lo + st;
    while (seq.size() * dmax(dw) < n) begin
      build_up(wrap, hi, st, u);
      seq = {seq, u, dn};
    end
    foreach (seq[i]) repeat (dmax(dw)) r.push_back(mk(1, seq[i], 1, 0, 0));
    @(posedge clk); #1;
    drive_cfg(lo, hi, st, dw, 1'b1);
    sw.start = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(r[i]);
    @(posedge clk); #1;
    sw.start = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    sw.abort = 1'b1;
    @(posedge clk); #1;
    sw.abort = 1'b0;
    @(negedge clk);
    check_quiet({name, "_abort"});
    check({name, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge clk);
  endtask

  task automatic do_bad(input string name, input int lo, input int hi, input int st);
    @(posedge clk); #1;
    drive_cfg(lo, hi, st, 2, 1'b0);
    sw.start = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    @(posedge clk); #1;
    sw.start = 1'b0;
    repeat (3) @(posedge clk);
    check({name, "_busy"}, int'(sw.busy), 0);
    wait_drain(name, 10);
  endtask

  initial begin
    int lo, hi, st, dw;
    sw.start = 1'b0;
    sw.abort = 1'b0;
    drive_cfg(0, 0, 0, 0, 1'b0);
    #1;
    check_quiet("reset");
    check("reset_done", int'(sw.done), 0);
    check("reset_cfg_err", int'(sw.cfg_err), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);

    do_sweep("basic", 10, 20, 5, 2, 1'b0);
    do_sweep("saturate", 250, 255, 4, 1, 1'b0);
    do_cont("cont", 0, 8, 4, 1, 20);
    do_bad("step_zero", 10, 20, 0);
    do_bad("lo_gt_hi", 30, 20, 5);
    do_sweep("degenerate", 7, 7, 3, 0, 1'b1);

    for (int k = 0; k < 12; k++) begin
      lo = $urandom_range(0, 255);
      hi = $urandom_range(lo, 255);
      st = $urandom_range(1, 40);
      dw = $urandom_range(0, 3);
      do_sweep("rand_sweep", lo, hi, st, dw, 1'($urandom));
    end
    for (int k = 0; k < 3; k++) begin
      lo = $urandom_range(0, 200);
      hi = $urandom_range(lo, 255);
      do_cont("rand_cont", lo, hi, $urandom_range(1, 60), $urandom_range(0, 2),
              $urandom_range(5, 40));
    end
    for (int k = 0; k < 3; k++) begin
      lo = $urandom_range(1, 255);
      do_bad("rand_bad", lo, $urandom_range(0, lo - 1), $urandom_range(0, 9));
    end

    // Asynchronous reset in the middle of a rising leg.
    @(posedge clk); #1;
    drive_cfg(0, 200, 10, 3, 1'b0);
    sw.start = 1'b1;
    for (int v = 0; v <= 200; v += 10) repeat (3) exp_q.push_back(mk(1, v, 1, 0, 0));
    @(posedge clk); #1;
    sw.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_quiet("async_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_quiet("post_rst");
    do_sweep("after_rst", 3, 9, 3, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
